xgmii_xbar: RTL and testbench

XGMII_XBAR -- requirements
Module: xgmii_xbar

---
 rtl/xgmii_xbar.sv | 140 ++++++++++++++
 tb/tb_xgmii_xbar.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xgmii_xbar.sv
// xgmii_xbar: N_PORTS x N_PORTS XGMII crossbar; each output forwards one selected receive port,
// with select/enable changes held pending until a frame boundary so no output emits a partial frame.
// Latency 1 clock rx -> tx; no backpressure (XGMII carries a word every cycle, config never stalls).
// Ports: clk_i, areset_i (async, active-high); xgmii_rxd_i/xgmii_rxc_i, port p at [64p+63:64p]/[8p+7:8p];
//   xgmii_txd_o/xgmii_txc_o with the same packing; cfg_we_i/cfg_port_i/cfg_sel_i/cfg_en_i write one
//   output's select and enable; pending_o flags outputs with a change waiting; fwd_o flags outputs in FWD.
module xgmii_xbar #(
  parameter int N_PORTS = 8,
  parameter int SEL_W   = 3
) (
  input  logic                   clk_i,
  input  logic                   areset_i,
  input  logic [N_PORTS*64-1:0]  xgmii_rxd_i,
  input  logic [N_PORTS*8-1:0]   xgmii_rxc_i,
  output logic [N_PORTS*64-1:0]  xgmii_txd_o,
  output logic [N_PORTS*8-1:0]   xgmii_txc_o,
  input  logic                   cfg_we_i,
  input  logic [SEL_W-1:0]       cfg_port_i,
  input  logic [SEL_W-1:0]       cfg_sel_i,
  input  logic                   cfg_en_i,
  output logic [N_PORTS-1:0]     pending_o,
  output logic [N_PORTS-1:0]     fwd_o
);

  localparam logic [63:0] IDLE_D = {8{8'h07}};
  localparam logic [7:0]  IDLE_C = 8'hFF;

  localparam logic [1:0] S_IDLE_OUT = 2'd0;
  localparam logic [1:0] S_WAIT_SOF = 2'd1;
  localparam logic [1:0] S_FWD      = 2'd2;

  // One extra bit so the range check also works when N_PORTS is a power of two.
  localparam logic [SEL_W:0] N_LIM = (SEL_W+1)'(N_PORTS);

  logic [63:0] rx_d [N_PORTS];
  logic [7:0]  rx_c [N_PORTS];
  logic        cfg_ok;

  for (genvar p = 0; p < N_PORTS; p++) begin : g_rx
    assign rx_d[p] = xgmii_rxd_i[64*p +: 64];
    assign rx_c[p] = xgmii_rxc_i[8*p +: 8];
  end

  // Writes naming a nonexistent port or source are dropped entirely.
  assign cfg_ok = cfg_we_i && ({1'b0, cfg_port_i} < N_LIM) && ({1'b0, cfg_sel_i} < N_LIM);

  for (genvar o = 0; o < N_PORTS; o++) begin : g_out
    logic [SEL_W-1:0] act_sel;
    logic             act_en;
    logic [SEL_W-1:0] pend_sel;
    logic             pend_en;
    logic             pend;
    logic             in_frame;
    logic [1:0]       state;
    logic [63:0]      tx_d;
    logic [7:0]       tx_c;

    logic [63:0]      src_d;
    logic [7:0]       src_c;
    logic             sof;
    logic             eof;
    logic             apply;
    logic             wr;

    always_comb begin
      src_d = rx_d[act_sel];
      src_c = rx_c[act_sel];
      sof   = (src_c[0] && (src_d[7:0] == 8'hFB)) || (src_c[4] && (src_d[39:32] == 8'hFB));
      eof   = 1'b0;
      for (int k = 0; k < 8; k++) begin
        if (src_c[k] && (src_d[8*k +: 8] == 8'hFD)) eof = 1'b1;
      end
      // A change may only land between frames; a SOF arriving this cycle would
      // start a frame, so it blocks the apply as well.
      apply = pend && ((state != S_FWD) || (!in_frame && !sof));
      wr    = cfg_ok && (cfg_port_i == SEL_W'(o));
    end

    always_ff @(posedge clk_i or posedge areset_i) begin
      if (areset_i) begin
        act_sel  <= SEL_W'(N_PORTS - 1 - o);
        act_en   <= 1'b1;
        pend_sel <= '0;
        pend_en  <= 1'b0;
        pend     <= 1'b0;
        in_frame <= 1'b0;
        state    <= S_WAIT_SOF;
        tx_d     <= IDLE_D;
        tx_c     <= IDLE_C;
      end else begin
        if (wr) begin
          pend_sel <= cfg_sel_i;
          pend_en  <= cfg_en_i;
          pend     <= 1'b1;
        end
        if (apply) begin
          // Applies the value pending before this cycle; a write landing now
          // stays pending (wr above keeps pend set).
          act_sel  <= pend_sel;
          act_en   <= pend_en;
          if (!wr) pend <= 1'b0;
          in_frame <= 1'b0;
          state    <= pend_en ? S_WAIT_SOF : S_IDLE_OUT;
          tx_d     <= IDLE_D;
          tx_c     <= IDLE_C;
        end else begin
          case (state)
            S_FWD: begin
              tx_d <= src_d;
              tx_c <= src_c;
              if (sof)      in_frame <= 1'b1;
              else if (eof) in_frame <= 1'b0;
            end
            S_WAIT_SOF: begin
              if (sof && act_en) begin
                tx_d     <= src_d;
                tx_c     <= src_c;
                in_frame <= 1'b1;
                state    <= S_FWD;
              end else begin
                tx_d <= IDLE_D;
                tx_c <= IDLE_C;
              end
            end
            default: begin
              tx_d <= IDLE_D;
              tx_c <= IDLE_C;
            end
          endcase
        end
      end
    end

    assign xgmii_txd_o[64*o +: 64] = tx_d;
    assign xgmii_txc_o[8*o +: 8]   = tx_c;
    assign pending_o[o]            = pend;
    assign fwd_o[o]                = (state == S_FWD);
  end

endmodule

// File: tb/tb_xgmii_xbar.sv
// tb_xgmii_xbar: directed scenarios against xgmii_xbar (8-port main instance, 5-port instance
// for out-of-range writes); each task drives its stimulus and compares outputs inline.
// Words are handled as 72-bit {ctrl, data}.
module tb_xgmii_xbar;

  localparam logic [71:0] W_IDLE = {8'hFF, 64'h0707070707070707};
  localparam logic [71:0] W_SOF  = {8'h01, 64'hD5555555555555FB};
  localparam logic [71:0] W_DAT  = {8'h00, 64'h1122334455667788};
  localparam logic [71:0] W_DAT2 = {8'h00, 64'h99AABBCCDDEEFF00};
  localparam logic [71:0] W_EOF  = {8'hFF, 64'h07070707070707FD};
  // Terminate in lane 2, start in lane 4.
  localparam logic [71:0] W_MIX  = {8'h1C, 64'h555555FB07FDBBAA};

  logic         clk = 1'b0;
  logic         areset_i = 1'b0;
  logic [511:0] rxd = {8{64'h0707070707070707}};
  logic [63:0]  rxc = {8{8'hFF}};
  logic [511:0] txd;
  logic [63:0]  txc;
  logic         cfg_we = 1'b0;
  logic [2:0]   cfg_port = 3'd0;
  logic [2:0]   cfg_sel = 3'd0;
  logic         cfg_en = 1'b0;
  logic [7:0]   pending;
  logic [7:0]   fwd;

  logic [319:0] rxd5 = {5{64'h0707070707070707}};
  logic [39:0]  rxc5 = {5{8'hFF}};
  logic [319:0] txd5;
  logic [39:0]  txc5;
  logic         cfg_we5 = 1'b0;
  logic [2:0]   cfg_port5 = 3'd0;
  logic [2:0]   cfg_sel5 = 3'd0;
  logic         cfg_en5 = 1'b0;
  logic [4:0]   pending5;
  logic [4:0]   fwd5;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  xgmii_xbar #(.N_PORTS(8), .SEL_W(3)) dut (
    .clk_i(clk), .areset_i(areset_i),
    .xgmii_rxd_i(rxd), .xgmii_rxc_i(rxc),
    .xgmii_txd_o(txd), .xgmii_txc_o(txc),
    .cfg_we_i(cfg_we), .cfg_port_i(cfg_port), .cfg_sel_i(cfg_sel), .cfg_en_i(cfg_en),
    .pending_o(pending), .fwd_o(fwd)
  );

  xgmii_xbar #(.N_PORTS(5), .SEL_W(3)) dut5 (
    .clk_i(clk), .areset_i(areset_i),
    .xgmii_rxd_i(rxd5), .xgmii_rxc_i(rxc5),
    .xgmii_txd_o(txd5), .xgmii_txc_o(txc5),
    .cfg_we_i(cfg_we5), .cfg_port_i(cfg_port5), .cfg_sel_i(cfg_sel5), .cfg_en_i(cfg_en5),
    .pending_o(pending5), .fwd_o(fwd5)
  );

  function automatic logic [71:0] tx_w(input int p);
    return {txc[8*p +: 8], txd[64*p +: 64]};
  endfunction

  function automatic logic [71:0] tx5_w(input int p);
    return {txc5[8*p +: 8], txd5[64*p +: 64]};
  endfunction

  task automatic set_rx(input int p, input logic [71:0] w);
    rxd[64*p +: 64] = w[63:0];
    rxc[8*p +: 8]   = w[71:64];
  endtask

  task automatic set_cfg(input logic we, input logic [2:0] port, input logic [2:0] sel, input logic en);
    cfg_we = we; cfg_port = port; cfg_sel = sel; cfg_en = en;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 areset_i = 1'b1;
    #1;
    for (int p = 0; p < 8; p++) begin
      checks++;
      if (tx_w(p) !== W_IDLE) begin errors++; $display("FAIL reset_tx%0d got %h exp %h", p, tx_w(p), W_IDLE); end
    end
    for (int p = 0; p < 5; p++) begin
      checks++;
      if (tx5_w(p) !== W_IDLE) begin errors++; $display("FAIL reset_tx5_%0d got %h exp %h", p, tx5_w(p), W_IDLE); end
    end
    checks++;
    if (pending !== 8'h00) begin errors++; $display("FAIL reset_pending got %h exp 00", pending); end
    checks++;
    if (fwd !== 8'h00) begin errors++; $display("FAIL reset_fwd got %h exp 00", fwd); end
    @(posedge clk);
    #1 areset_i = 1'b0;
  endtask

  // Port 7 (mirror source of output 0) sends SOF in cycle 5; it appears on output 0 in cycle 6.
  task automatic test_sof_forward();
    for (int c = 1; c <= 5; c++) begin
      set_rx(7, (c == 5) ? W_SOF : W_IDLE);
      step();
      checks++;
      if (tx_w(0) !== ((c == 5) ? W_SOF : W_IDLE)) begin
        errors++; $display("FAIL sof_fwd cyc%0d tx0 got %h exp %h", c + 1, tx_w(0), (c == 5) ? W_SOF : W_IDLE);
      end
      checks++;
      if (fwd[0] !== (c == 5)) begin errors++; $display("FAIL sof_fwd cyc%0d fwd0 got %b exp %b", c + 1, fwd[0], c == 5); end
    end
    checks++;
    if (tx_w(1) !== W_IDLE) begin errors++; $display("FAIL sof_fwd tx1 got %h exp %h", tx_w(1), W_IDLE); end
  endtask

  // Output 0 mid-frame on port 7; rewritten to 5 then 3. Change waits for EOF, then port 3's next SOF.
  task automatic test_pending_midframe();
    logic [71:0] s7 [8];
    logic [71:0] s3 [8];
    logic [71:0] ex [8];
    logic        we [8];
    logic [2:0]  sl [8];
    logic        ep [8];
    logic        ef [8];
    s7 = '{W_DAT, W_DAT2, W_EOF, W_IDLE, W_IDLE, W_IDLE, W_IDLE, W_IDLE};
    s3 = '{W_IDLE, W_SOF, W_DAT, W_DAT2, W_EOF, W_IDLE, W_SOF, W_DAT};
    ex = '{W_DAT, W_DAT2, W_EOF, W_IDLE, W_IDLE, W_IDLE, W_SOF, W_DAT};
    we = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    sl = '{3'd5, 3'd3, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    ep = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    ef = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++) begin
      set_rx(7, s7[i]);
      set_rx(3, s3[i]);
      set_cfg(we[i], 3'd0, sl[i], 1'b1);
      step();
      checks++;
      if (tx_w(0) !== ex[i]) begin errors++; $display("FAIL midframe step%0d tx0 got %h exp %h", i, tx_w(0), ex[i]); end
      checks++;
      if (pending[0] !== ep[i]) begin errors++; $display("FAIL midframe step%0d pend0 got %b exp %b", i, pending[0], ep[i]); end
      checks++;
      if (fwd[0] !== ef[i]) begin errors++; $display("FAIL midframe step%0d fwd0 got %b exp %b", i, fwd[0], ef[i]); end
    end
    set_cfg(1'b0, 3'd0, 3'd0, 1'b0);
  endtask

  // Output 1 (source 6, waiting for SOF) disabled: IDLE forever even when port 6 sends frames.
  task automatic test_disable();
    logic [71:0] s6 [5];
    s6 = '{W_IDLE, W_SOF, W_SOF, W_DAT, W_EOF};
    for (int i = 0; i < 5; i++) begin
      set_rx(6, s6[i]);
      set_cfg(i == 0, 3'd1, 3'd6, 1'b0);
      step();
      checks++;
      if (tx_w(1) !== W_IDLE) begin errors++; $display("FAIL disable step%0d tx1 got %h exp %h", i, tx_w(1), W_IDLE); end
      checks++;
      if (pending[1] !== (i == 0)) begin errors++; $display("FAIL disable step%0d pend1 got %b exp %b", i, pending[1], i == 0); end
      checks++;
      if (fwd[1] !== 1'b0) begin errors++; $display("FAIL disable step%0d fwd1 got %b exp 0", i, fwd[1]); end
    end
    set_cfg(1'b0, 3'd0, 3'd0, 1'b0);
    set_rx(6, W_IDLE);
  endtask

  // Output 0 in frame on port 3. A terminate+start word keeps the frame open, so the pending
  // change to 7 waits for the real EOF. A write to 6 in the apply cycle stays pending and
  // applies one cycle later.
  task automatic test_terminate_sof();
    logic [71:0] s3 [9];
    logic [71:0] s6 [9];
    logic [71:0] ex [9];
    logic        we [9];
    logic [2:0]  sl [9];
    logic        ep [9];
    logic        ef [9];
    s3 = '{W_DAT, W_MIX, W_DAT, W_EOF, W_IDLE, W_IDLE, W_IDLE, W_IDLE, W_IDLE};
    s6 = '{W_IDLE, W_IDLE, W_IDLE, W_IDLE, W_IDLE, W_IDLE, W_SOF, W_EOF, W_IDLE};
    ex = '{W_DAT, W_MIX, W_DAT, W_EOF, W_IDLE, W_IDLE, W_SOF, W_EOF, W_IDLE};
    we = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    sl = '{3'd7, 3'd0, 3'd0, 3'd0, 3'd6, 3'd0, 3'd0, 3'd0, 3'd0};
    ep = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    ef = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 9; i++) begin
      set_rx(3, s3[i]);
      set_rx(6, s6[i]);
      set_cfg(we[i], 3'd0, sl[i], 1'b1);
      step();
      checks++;
      if (tx_w(0) !== ex[i]) begin errors++; $display("FAIL term_sof step%0d tx0 got %h exp %h", i, tx_w(0), ex[i]); end
      checks++;
      if (pending[0] !== ep[i]) begin errors++; $display("FAIL term_sof step%0d pend0 got %b exp %b", i, pending[0], ep[i]); end
      checks++;
      if (fwd[0] !== ef[i]) begin errors++; $display("FAIL term_sof step%0d fwd0 got %b exp %b", i, fwd[0], ef[i]); end
    end
    set_cfg(1'b0, 3'd0, 3'd0, 1'b0);
  endtask

  // 5-port instance: sources/ports 5..7 do not exist, so those writes must change nothing.
  task automatic test_bad_sel();
    cfg_we5 = 1'b1; cfg_port5 = 3'd1; cfg_sel5 = 3'd5; cfg_en5 = 1'b1;
    step();
    checks++;
    if (pending5 !== 5'b00000) begin errors++; $display("FAIL bad_sel sel5 pending got %b exp 00000", pending5); end
    cfg_port5 = 3'd0; cfg_sel5 = 3'd7; cfg_en5 = 1'b0;
    step();
    checks++;
    if (pending5 !== 5'b00000) begin errors++; $display("FAIL bad_sel sel7 pending got %b exp 00000", pending5); end
    cfg_port5 = 3'd6; cfg_sel5 = 3'd0;
    step();
    checks++;
    if (pending5 !== 5'b00000) begin errors++; $display("FAIL bad_sel port6 pending got %b exp 00000", pending5); end
    cfg_we5 = 1'b0;
    rxd5[4*64 +: 64] = W_SOF[63:0];
    rxc5[4*8 +: 8]   = W_SOF[71:64];
    step();
    checks++;
    if (tx5_w(0) !== W_SOF) begin errors++; $display("FAIL bad_sel tx0 got %h exp %h", tx5_w(0), W_SOF); end
    checks++;
    if (fwd5 !== 5'b00001) begin errors++; $display("FAIL bad_sel fwd got %b exp 00001", fwd5); end
    cfg_we5 = 1'b1; cfg_port5 = 3'd2; cfg_sel5 = 3'd0; cfg_en5 = 1'b1;
    step();
    checks++;
    if (pending5 !== 5'b00100) begin errors++; $display("FAIL bad_sel valid pending got %b exp 00100", pending5); end
    cfg_we5 = 1'b0;
  endtask

  // One-cycle reset mid-frame: outputs drop to IDLE at once and the mirror map comes back.
  task automatic test_reset_midframe();
    set_rx(6, W_SOF);
    set_cfg(1'b1, 3'd2, 3'd0, 1'b1);
    step();
    checks++;
    if (tx_w(0) !== W_SOF) begin errors++; $display("FAIL rst_mid pre tx0 got %h exp %h", tx_w(0), W_SOF); end
    checks++;
    if (pending !== 8'h04) begin errors++; $display("FAIL rst_mid pre pending got %h exp 04", pending); end
    set_rx(6, W_DAT);
    set_cfg(1'b1, 3'd5, 3'd0, 1'b1);
    step();
    checks++;
    if (tx_w(0) !== W_DAT) begin errors++; $display("FAIL rst_mid data tx0 got %h exp %h", tx_w(0), W_DAT); end
    checks++;
    if (pending !== 8'h20) begin errors++; $display("FAIL rst_mid data pending got %h exp 20", pending); end
    set_cfg(1'b0, 3'd0, 3'd0, 1'b0);
    areset_i = 1'b1;
    #1;
    for (int p = 0; p < 8; p++) begin
      checks++;
      if (tx_w(p) !== W_IDLE) begin errors++; $display("FAIL rst_mid tx%0d got %h exp %h", p, tx_w(p), W_IDLE); end
    end
    checks++;
    if (pending !== 8'h00) begin errors++; $display("FAIL rst_mid pending got %h exp 00", pending); end
    checks++;
    if (fwd !== 8'h00) begin errors++; $display("FAIL rst_mid fwd got %h exp 00", fwd); end
    @(posedge clk);
    #1 areset_i = 1'b0;
    set_rx(7, W_DAT);
    set_rx(6, W_SOF);
    set_rx(5, W_SOF);
    step();
    checks++;
    if (tx_w(0) !== W_IDLE) begin errors++; $display("FAIL rst_mid post tx0 got %h exp %h", tx_w(0), W_IDLE); end
    checks++;
    if (tx_w(1) !== W_SOF) begin errors++; $display("FAIL rst_mid post tx1 got %h exp %h", tx_w(1), W_SOF); end
    checks++;
    if (tx_w(2) !== W_SOF) begin errors++; $display("FAIL rst_mid post tx2 got %h exp %h", tx_w(2), W_SOF); end
    checks++;
    if (fwd !== 8'h06) begin errors++; $display("FAIL rst_mid post fwd got %h exp 06", fwd); end
    set_rx(7, W_SOF);
    set_rx(6, W_DAT);
    set_rx(5, W_DAT);
    step();
    checks++;
    if (tx_w(0) !== W_SOF) begin errors++; $display("FAIL rst_mid mirror tx0 got %h exp %h", tx_w(0), W_SOF); end
    checks++;
    if (tx_w(1) !== W_DAT) begin errors++; $display("FAIL rst_mid mirror tx1 got %h exp %h", tx_w(1), W_DAT); end
    checks++;
    if (fwd !== 8'h07) begin errors++; $display("FAIL rst_mid mirror fwd got %h exp 07", fwd); end
  endtask

  initial begin
    test_reset();
    test_sof_forward();
    test_pending_midframe();
    test_disable();
    test_terminate_sof();
    test_bad_sel();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
